// File: rtl/spi_flash_cmd.sv
// SPI mode-0 command engine for an external NOR flash: opcode, optional 24-bit
// address and a byte-counted read or page-program data phase per handshake.
module spi_flash_cmd #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HIGH = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ack,
    input  logic [23:0] addr,
    input  logic [8:0]  size,
    input  logic [7:0]  data_in,
    output logic        data_req,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] REQ_AT  = CNT_W'(2 * CLK_DIV - 3);
    localparam logic [CNT_W-1:0] CSH_END = CNT_W'(CS_HIGH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        HOLD,
        CSH,
        ACK
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] div_cnt, div_d;
    logic [2:0]       bit_cnt, bit_d;
    logic [4:0]       addr_cnt, addr_d;
    logic [8:0]       byte_cnt, byte_d;
    logic [30:0]      tx_sr, tx_d;
    logic [6:0]       rx_sr, rx_d;
    logic             has_addr_q, has_addr_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             data_en_q, data_en_d;
    logic             cs_n_d, sck_d, mosi_d, ack_d, req_d, valid_d;
    logic [7:0]       dout_d;
    logic             dec_addr, dec_rd, dec_wr;
    logic             pp_next;

    // Opcode classification
    always_comb begin
        dec_addr = 1'b0;
        dec_rd   = 1'b0;
        dec_wr   = 1'b0;
        case (cmd)
            8'h03:        begin dec_addr = 1'b1; dec_rd = 1'b1; end
            8'h05:        dec_rd = 1'b1;
            8'h02:        begin dec_addr = 1'b1; dec_wr = 1'b1; end
            8'hD8, 8'h20: dec_addr = 1'b1;
            default:      ;
        endcase
    end

    // Next state, counters and next values of the registered outputs
    always_comb begin
        state_d    = state;
        div_d      = div_cnt;
        bit_d      = bit_cnt;
        addr_d     = addr_cnt;
        byte_d     = byte_cnt;
        tx_d       = tx_sr;
        rx_d       = rx_sr;
        has_addr_d = has_addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        data_en_d  = data_en_q;
        cs_n_d     = spi_cs_n;
        sck_d      = spi_sck;
        mosi_d     = spi_mosi;
        ack_d      = 1'b0;
        req_d      = 1'b0;
        valid_d    = 1'b0;
        dout_d     = data_out;

        // Current bit is the last one before a page-program data byte
        pp_next = wr_q && data_en_q &&
                  ((state == ADDR && addr_cnt == 5'd23) ||
                   (state == CMD && !has_addr_q && bit_cnt == 3'd7) ||
                   (state == DATA && bit_cnt == 3'd7 && byte_cnt != 9'd1));

        case (state)
            IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                if (cmd_valid) begin
                    state_d    = CMD;
                    div_d      = '0;
                    bit_d      = '0;
                    addr_d     = '0;
                    byte_d     = size;
                    tx_d       = {cmd[6:0], addr};
                    has_addr_d = dec_addr;
                    rd_d       = dec_rd;
                    wr_d       = dec_wr;
                    data_en_d  = (dec_rd || dec_wr) && (size != 9'd0);
                    cs_n_d     = 1'b0;
                    mosi_d     = cmd[7];
                end
            end
            CMD, ADDR, DATA: begin
                if (div_cnt == RISE_AT) begin
                    sck_d = 1'b1;
                    if (state == DATA && rd_q) begin
                        rx_d = {rx_sr[5:0], spi_miso};
                        if (bit_cnt == 3'd7) begin
                            dout_d  = {rx_sr, spi_miso};
                            valid_d = 1'b1;
                        end
                    end
                end
                if (div_cnt == REQ_AT && pp_next) begin
                    req_d = 1'b1;
                end
                if (div_cnt == BIT_END) begin
                    div_d  = '0;
                    bit_d  = bit_cnt + 3'd1;
                    sck_d  = 1'b0;
                    tx_d   = {tx_sr[29:0], 1'b0};
                    mosi_d = tx_sr[30];
                    case (state)
                        CMD: begin
                            if (bit_cnt == 3'd7) begin
                                state_d = has_addr_q ? ADDR : (data_en_q ? DATA : HOLD);
                            end
                        end
                        ADDR: begin
                            addr_d = addr_cnt + 5'd1;
                            if (addr_cnt == 5'd23) begin
                                state_d = data_en_q ? DATA : HOLD;
                            end
                        end
                        default: begin
                            if (bit_cnt == 3'd7) begin
                                byte_d = byte_cnt - 9'd1;
                                if (byte_cnt == 9'd1) begin
                                    state_d = HOLD;
                                end
                            end
                        end
                    endcase
                    // Reads keep MOSI low; program bytes load fresh from data_in
                    if (state_d == DATA && rd_q) begin
                        mosi_d = 1'b0;
                    end else if (state_d == DATA && bit_cnt == 3'd7) begin
                        tx_d   = {data_in[6:0], 24'd0};
                        mosi_d = data_in[7];
                    end else if (state_d == HOLD) begin
                        mosi_d = 1'b0;
                    end
                end else begin
                    div_d = div_cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                sck_d = 1'b0;
                if (div_cnt == RISE_AT) begin
                    state_d = CSH;
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                end else begin
                    div_d = div_cnt + CNT_W'(1);
                end
            end
            CSH: begin
                if (div_cnt == CSH_END) begin
                    state_d = ACK;
                    div_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    div_d = div_cnt + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                div_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            addr_cnt   <= '0;
            byte_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            has_addr_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            data_en_q  <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            cmd_ack    <= 1'b0;
            data_req   <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            state      <= state_d;
            div_cnt    <= div_d;
            bit_cnt    <= bit_d;
            addr_cnt   <= addr_d;
            byte_cnt   <= byte_d;
            tx_sr      <= tx_d;
            rx_sr      <= rx_d;
            has_addr_q <= has_addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            data_en_q  <= data_en_d;
            spi_cs_n   <= cs_n_d;
            spi_sck    <= sck_d;
            spi_mosi   <= mosi_d;
            cmd_ack    <= ack_d;
            data_req   <= req_d;
            data_valid <= valid_d;
            data_out   <= dout_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Bench for spi_flash_cmd: a bus monitor plus flash/source model, with each
// transaction's expected bit stream and timing computed from the command.
module tb_spi_flash_cmd;

    localparam int D   = 2;
    localparam int CSH = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  cmd = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ack;
    logic [23:0] addr = 24'h0;
    logic [8:0]  size = 9'h0;
    logic [7:0]  data_in = 8'h00;
    logic        data_req;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    spi_flash_cmd #(.CLK_DIV(D), .CS_HIGH(CSH)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ack    (cmd_ack),
        .addr       (addr),
        .size       (size),
        .data_in    (data_in),
        .data_req   (data_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event logs written only by the monitor
    int          cs_fall_q[$];
    int          cs_rise_q[$];
    int          ack_q[$];
    int          req_q[$];
    int          dv_q[$];
    logic        mosi_q[$];
    logic [7:0]  dvb_q[$];
    logic        miso_stream [0:4199];
    logic [7:0]  wr_stream [0:4095];
    logic [7:0]  pay [0:511];
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    logic        req_flag = 1'b0;
    int          bit_idx = 0;

    always @(negedge sys_clk) begin
        if (!spi_cs_n && prev_cs) cs_fall_q.push_back(cyc);
        if (spi_cs_n && !prev_cs) cs_rise_q.push_back(cyc);
        if (!spi_cs_n && spi_sck && !prev_sck) mosi_q.push_back(spi_mosi);
        if (spi_cs_n) bit_idx = 0;
        else if (prev_sck && !spi_sck && bit_idx < 4199) bit_idx = bit_idx + 1;
        spi_miso = miso_stream[bit_idx];
        if (cmd_ack) ack_q.push_back(cyc);
        if (data_req) req_q.push_back(cyc);
        if (data_valid) begin
            dv_q.push_back(cyc);
            dvb_q.push_back(data_out);
        end
        req_flag = data_req;
        prev_cs  = spi_cs_n;
        prev_sck = spi_sck;
    end

    // Write-data source: valid only in the cycle after data_req, noise otherwise
    always @(posedge sys_clk) begin
        #1;
        if (req_flag && req_q.size() > 0) data_in = wr_stream[req_q.size() - 1];
        else data_in = 8'($urandom);
    end

    int         checks = 0;
    int         errors = 0;
    int         done_cmds = 0;
    logic [7:0] exp_dout = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command (caller sits 1 time unit after a rising edge) and check it
    task automatic do_cmd(input logic [7:0] c, input logic [23:0] a, input logic [8:0] s);
        bit   ha, rd, wr, acked;
        int   nd, hdr, n, t, bad, cnt, fall, rise, prev_rise;
        int   b_bits, b_req, b_dv, b_ack, b_fall, b_rise;
        logic exp_bits[$];
        logic [7:0] byt;
        ha  = (c == 8'h03) || (c == 8'h02) || (c == 8'hD8) || (c == 8'h20);
        rd  = (c == 8'h03) || (c == 8'h05);
        wr  = (c == 8'h02);
        nd  = (rd || wr) ? int'(s) : 0;
        hdr = ha ? 32 : 8;
        n   = hdr + 8 * nd;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(c[i]);
        if (ha) for (int i = 23; i >= 0; i--) exp_bits.push_back(a[i]);
        for (int k = 0; k < nd; k++) begin
            byt = pay[k];
            for (int i = 7; i >= 0; i--) exp_bits.push_back(wr ? byt[i] : 1'b0);
        end
        for (int i = 0; i <= n; i++) miso_stream[i] = 1'($urandom);
        for (int k = 0; k < nd && rd; k++) begin
            byt = pay[k];
            for (int i = 0; i < 8; i++) miso_stream[hdr + 8 * k + i] = byt[7 - i];
        end
        for (int k = 0; k < nd && wr; k++) wr_stream[req_q.size() + k] = pay[k];
        b_bits = mosi_q.size();
        b_req  = req_q.size();
        b_dv   = dv_q.size();
        b_ack  = ack_q.size();
        b_fall = cs_fall_q.size();
        b_rise = cs_rise_q.size();
        prev_rise = (b_rise > 0) ? cs_rise_q[b_rise - 1] : -1;

        cmd = c; addr = a; size = s; cmd_valid = 1'b1;
        t = cyc;
        @(posedge sys_clk); #1;
        cmd = 8'($urandom); addr = 24'($urandom); size = 9'($urandom);
        acked = 1'b0;
        for (int i = 0; i < n * 2 * D + D + CSH + 20; i++) begin
            @(negedge sys_clk);
            if (cmd_ack) begin acked = 1'b1; break; end
        end
        chk("ack_seen", 32'(acked), 32'd1);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        if (acked) begin
            done_cmds++;
            fall = (cs_fall_q.size() > b_fall) ? cs_fall_q[b_fall] : -1;
            rise = (cs_rise_q.size() > b_rise) ? cs_rise_q[b_rise] : -1;
            chk("cs_fall_cycle", 32'(fall), 32'(t + 1));
            chk("cs_low_len", 32'(rise - fall), 32'(n * 2 * D + D));
            chk("ack_cycle", 32'(ack_q[b_ack]), 32'(t + 1 + n * 2 * D + D + CSH));
            if (prev_rise >= 0) chk("cs_gap_ok", 32'(fall - prev_rise >= CSH), 32'd1);
            cnt = mosi_q.size() - b_bits;
            chk("sck_pulses", 32'(cnt), 32'(n));
            bad = 0;
            for (int i = 0; i < n && i < cnt; i++) if (mosi_q[b_bits + i] !== exp_bits[i]) bad++;
            chk("mosi_bits_bad", 32'(bad), 32'd0);
            cnt = req_q.size() - b_req;
            chk("data_req_count", 32'(cnt), 32'(wr ? nd : 0));
            bad = 0;
            for (int k = 0; k < cnt && k < nd; k++)
                if (req_q[b_req + k] != t + 1 + (hdr + 8 * k) * 2 * D - 2) bad++;
            chk("data_req_timing_bad", 32'(bad), 32'd0);
            cnt = dv_q.size() - b_dv;
            chk("data_valid_count", 32'(cnt), 32'(rd ? nd : 0));
            bad = 0;
            for (int k = 0; k < cnt && k < nd; k++) begin
                if (dvb_q[b_dv + k] !== pay[k]) bad++;
                if (dv_q[b_dv + k] != t + 1 + (hdr + 8 * k + 7) * 2 * D + D) bad++;
            end
            chk("data_valid_bad", 32'(bad), 32'd0);
            if (rd && nd > 0) exp_dout = pay[nd - 1];
            chk("data_out_hold", 32'(data_out), 32'(exp_dout));
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge sys_clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_req, b_ack;
        bit seen;
        logic [7:0] op;
        for (int i = 0; i < 4200; i++) miso_stream[i] = 1'b0;
        for (int i = 0; i < 4096; i++) wr_stream[i] = 8'h00;
        for (int i = 0; i < 512; i++) pay[i] = 8'h00;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_ack_req_dv", 32'({cmd_ack, data_req, data_valid, spi_mosi}), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // WREN, RDSR, READ, PP
        do_cmd(8'h06, 24'h0, 9'd0);
        idle_cycles(2);
        pay[0] = 8'h03;
        do_cmd(8'h05, 24'h0, 9'd1);
        idle_cycles(3);
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        do_cmd(8'h03, 24'h012345, 9'd4);
        idle_cycles(1);
        pay[0] = 8'hA5; pay[1] = 8'h3C;
        do_cmd(8'h02, 24'h000100, 9'd2);
        idle_cycles(2);
        // SE then BE back-to-back; size ignored for both
        do_cmd(8'hD8, 24'hABCDEF, 9'd5);
        do_cmd(8'hC7, 24'h000000, 9'd7);
        idle_cycles(2);

        // Reset during the first byte of a PP data phase
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        for (int k = 0; k < 3; k++) wr_stream[req_q.size() + k] = pay[k];
        b_req = req_q.size();
        b_ack = ack_q.size();
        cmd = 8'h02; addr = 24'h001000; size = 9'd3; cmd_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (req_q.size() > b_req) begin seen = 1'b1; break; end
        end
        chk("rst_pp_req_seen", 32'(seen), 32'd1);
        idle_cycles(4);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_outs", 32'({cmd_ack, data_req, data_valid, spi_mosi}), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        exp_dout = 8'h00;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        idle_cycles(60);
        chk("abort_no_ack", 32'(ack_q.size()), 32'(b_ack));
        do_cmd(8'h06, 24'h0, 9'd0);
        idle_cycles(1);

        // Randomized commands, including unknown opcodes
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 7))
                0: op = 8'h06;
                1: op = 8'h05;
                2: op = 8'h03;
                3: op = 8'h02;
                4: op = 8'hD8;
                5: op = 8'h20;
                6: op = 8'hC7;
                default: op = 8'($urandom);
            endcase
            for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
            do_cmd(op, 24'($urandom), 9'($urandom_range(0, 6)));
            idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(20);
        chk("total_acks", 32'(ack_q.size()), 32'(done_cmds));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
